// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill
// Purpose  : AXI4 INCR read-burst master that refills one instruction-cache line
// Revision : 1.0
// ============================================================================
module icache_refill #(
  parameter int LINE_WORDS = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  // line-fill request
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [31:0]             req_addr_i,
  // filled line
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [32*LINE_WORDS-1:0] resp_line_o,
  output logic                    resp_err_o,
  // AXI4 read address channel
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [31:0]             araddr_o,
  output logic [3:0]              arid_o,
  output logic [7:0]              arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  // AXI4 read data channel
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [63:0]             rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rlast_i,
  input  logic [3:0]              rid_i
);

  localparam int          c_cnt_w     = $clog2(LINE_WORDS);
  localparam logic [31:0] c_off_mask  = 32'(4*LINE_WORDS-1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(LINE_WORDS-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [31:0]               r_base;
  logic [32*LINE_WORDS-1:0]  r_line;
  logic                      r_err;
  logic [c_cnt_w-1:0]        r_cnt;

  logic                      w_accept;
  logic                      w_beat;
  logic                      w_last_cnt;
  logic                      w_end;
  logic                      w_len_err;
  logic                      w_lane;
  logic [31:0]               w_word;
  logic [31:0]               w_req_base;
  logic                      w_unused;

  assign w_req_base = req_addr_i & ~c_off_mask;
  assign w_accept   = req_valid_i && req_ready_o;
  assign w_beat     = rvalid_i && rready_o;
  assign w_last_cnt = (r_cnt == c_last_cnt);
  assign w_end      = w_beat && (rlast_i || w_last_cnt);
  // rlast must coincide exactly with the final counted beat
  assign w_len_err  = w_beat && (rlast_i != w_last_cnt);
  // base has bits [1:0] clear, so bit 2 of base + 4*cnt needs no carry term
  assign w_lane     = r_base[2] ^ r_cnt[0];
  assign w_word     = w_lane ? rdata_i[63:32] : rdata_i[31:0];
  assign w_unused   = ^rid_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready_o  = 1'b0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    resp_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready_o = !reset;
        if (req_valid_i && !reset) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rready_o = 1'b1;
        if (w_end) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_base <= '0;
      r_line <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_base <= w_req_base;
      r_line <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_beat) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (r_cnt == c_cnt_w'(i)) begin
          r_line[32*i +: 32] <= w_word;
        end
      end
      r_err <= r_err | (rresp_i != 2'b00) | w_len_err;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign araddr_o    = r_base;
  assign arid_o      = 4'(AXI_ID);
  assign arlen_o     = 8'(LINE_WORDS-1);
  assign arsize_o    = 3'b010;
  assign arburst_o   = 2'b01;
  assign resp_line_o = r_line;
  assign resp_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// Bench for icache_refill: directed and random line fills, expected lines queued
// at issue time and compared by a handshake monitor.
module tb_icache_refill;
  localparam int LW = 4;
  localparam int LB = 32*LW;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready_o;
  logic [31:0]   req_addr;
  logic          resp_valid_o, resp_ready, resp_err_o;
  logic [LB-1:0] resp_line_o;
  logic          arvalid_o, arready;
  logic [31:0]   araddr_o;
  logic [3:0]    arid_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          rvalid, rready_o, rlast;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic [3:0]    rid;

  always #5 clock = ~clock;

  icache_refill #(.LINE_WORDS(LW), .AXI_ID(0)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_line_o(resp_line_o), .resp_err_o(resp_err_o),
    .arvalid_o(arvalid_o), .arready_i(arready), .araddr_o(araddr_o),
    .arid_o(arid_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid), .rready_o(rready_o), .rdata_i(rdata), .rresp_i(rresp),
    .rlast_i(rlast), .rid_i(rid)
  );

  logic [31:0]   ar_q[$];
  logic [LB-1:0] line_q[$];
  logic          err_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  always @(negedge clock) begin : mon
    logic [31:0]   ea;
    logic [LB-1:0] el;
    logic          ee;
    if (!reset && arvalid_o && arready) begin
      if (ar_q.size() == 0) begin
        check("ar_unexpected", 1, 0);
      end else begin
        ea = ar_q.pop_front();
        check("araddr", araddr_o, ea);
        check("arlen", arlen_o, LW-1);
        check("arsize", arsize_o, 2);
        check("arburst", arburst_o, 1);
        check("arid", arid_o, 0);
      end
    end
    if (!reset && resp_valid_o && resp_ready) begin
      if (line_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        el = line_q.pop_front();
        ee = err_q.pop_front();
        check("resp_line", resp_line_o, el);
        check("resp_err", resp_err_o, ee);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // gap: 0 none, 1 alternate cycles, 2 random. last_mode: 0 normal, 1 early at early_at, 2 missing.
  task automatic run_txn(input logic [31:0] addr, input int ar_wait, input int gap,
                         input int err_beat, input int last_mode, input int early_at,
                         input int resp_wait, input int rst_after, input bit chk_lat);
    logic [31:0]   base, a, w;
    logic [LB-1:0] eline;
    logic          eerr;
    int            n, t, acc;
    base = addr & ~32'(4*LW-1);
    n    = (last_mode == 1) ? early_at + 1 : LW;
    eline = '0;
    for (int k = 0; k < n; k++) eline[32*k +: 32] = mem_word(base + 32'(4*k));
    eerr = (err_beat >= 0 && err_beat < n) || (last_mode != 0);
    ar_q.push_back(base);
    if (rst_after < 0) begin
      line_q.push_back(eline);
      err_q.push_back(eerr);
    end

    req_valid = 1'b1;
    req_addr  = addr;
    t = 0;
    while (!req_ready_o && t < 50) begin step(); t++; end
    check("req_ready_idle", req_ready_o, 1);
    acc = cyc;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;

    for (int i = 0; i < ar_wait; i++) begin
      check("arvalid_hold", arvalid_o, 1);
      check("araddr_hold", araddr_o, base);
      step();
    end
    check("arvalid", arvalid_o, 1);
    arready = 1'b1;
    step();
    arready = 1'b0;

    for (int k = 0; k < n; k++) begin
      if (k == rst_after) begin
        reset = 1'b1;
        step();
        check("rst_arvalid", arvalid_o, 0);
        check("rst_rready", rready_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_resp_err", resp_err_o, 0);
        check("rst_resp_line", resp_line_o, 0);
        check("rst_araddr", araddr_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready_o, 1);
        return;
      end
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        rvalid = 1'b0;
        step();
      end
      check("rready_data", rready_o, 1);
      a = base + 32'(4*k);
      w = mem_word(a);
      rvalid = 1'b1;
      rdata  = a[2] ? {w, ~w} : {~w, w};
      rresp  = (k == err_beat) ? 2'($urandom_range(1, 3)) : 2'b00;
      rlast  = (last_mode == 1) ? (k == early_at) : (last_mode == 2) ? 1'b0 : (k == LW-1);
      rid    = 4'($urandom);
      step();
    end
    if (last_mode == 2) begin
      rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      rresp = 2'b11;
      rlast = 1'b1;
    end else begin
      rvalid = 1'b0;
    end

    t = 0;
    while (!resp_valid_o && t < 50) begin step(); t++; end
    check("resp_valid", resp_valid_o, 1);
    if (chk_lat) check("latency", cyc - acc, 2 + LW);
    if (resp_wait > 0) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
    end
    for (int i = 0; i < resp_wait; i++) begin
      check("stall_resp_valid", resp_valid_o, 1);
      check("stall_resp_line", resp_line_o, eline);
      check("stall_resp_err", resp_err_o, eerr);
      check("stall_req_ready", req_ready_o, 0);
      check("stall_rready", rready_o, 0);
      step();
    end
    req_valid  = 1'b0;
    check("resp_rready", rready_o, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    rvalid     = 1'b0;
    check("resp_dropped", resp_valid_o, 0);
    check("req_ready_again", req_ready_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    step(); step();
    check("reset_req_ready", req_ready_o, 0);
    check("reset_arvalid", arvalid_o, 0);
    check("reset_rready", rready_o, 0);
    check("reset_resp_valid", resp_valid_o, 0);
    check("reset_resp_err", resp_err_o, 0);
    check("reset_resp_line", resp_line_o, 0);
    check("reset_araddr", araddr_o, 0);
    reset = 1'b0;
    step();

    run_txn(32'h8000_0014, 0, 0, -1, 0, 0, 0, -1, 1'b1);  // basic fill, latency
    run_txn(32'h1234_5678, 5, 0, -1, 0, 0, 0, -1, 1'b0);  // AR backpressure
    run_txn(32'h0000_0FFC, 0, 1, -1, 0, 0, 3, -1, 1'b0);  // R gaps, resp stall
    run_txn(32'hC000_0040, 0, 0,  1, 0, 0, 0, -1, 1'b0);  // error beat 1
    run_txn(32'hA000_0020, 0, 0, -1, 1, 2, 0, -1, 1'b0);  // early rlast on beat 2
    run_txn(32'hB000_0030, 0, 0, -1, 2, 0, 1, -1, 1'b0);  // missing rlast
    run_txn(32'h7000_0008, 1, 0, -1, 0, 0, 0,  2, 1'b0);  // reset after 2 beats
    run_txn(32'h7000_0008, 0, 0, -1, 0, 0, 0, -1, 1'b1);  // clean fill after reset

    for (int i = 0; i < 40; i++) begin
      int eb, lm, r;
      eb = $urandom_range(0, 2*LW-1);
      if (eb >= LW) eb = -1;
      r  = $urandom_range(0, 9);
      lm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      run_txn($urandom, $urandom_range(0, 3), 2, eb, lm, $urandom_range(0, LW-2),
              $urandom_range(0, 2), -1, 1'b0);
    end

    step(); step();
    check("ar_queue_drained", ar_q.size(), 0);
    check("resp_queue_drained", line_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill.md
Name: icache_refill

Overview:
AXI4 read-burst master that fills one instruction-cache line from the AXI4 memory slave (pmem) downstream. It accepts a line-miss request over a valid/ready interface and issues one INCR burst of LINE_WORDS 32-bit beats. It assembles the beats into a line buffer and returns the complete line with an error flag. It has no write channels: AW/W/B towards pmem are tied off at the top level.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16
AXI_ID, 0, value driven on arid_o

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid_i  input  1  line-fill request valid
req_ready_o  output  1  request accepted when high with req_valid_i
req_addr_i  input  32  miss address; low log2(4*LINE_WORDS) bits ignored
resp_valid_o  output  1  filled line available
resp_ready_i  input  1  consumer accepts line
resp_line_o  output  32*LINE_WORDS  line data; word k in bits [32k+31:32k]
resp_err_o  output  1  at least one beat had nonzero rresp, or burst length was wrong
arvalid_o  output  1  AR valid
arready_i  input  1  AR ready
araddr_o  output  32  line-aligned burst base address
arid_o  output  4  AXI_ID
arlen_o  output  8  LINE_WORDS-1
arsize_o  output  3  3'b010 (4 bytes)
arburst_o  output  2  2'b01 (INCR)
rvalid_i  input  1  R valid
rready_o  output  1  R ready
rdata_i  input  64  R data
rresp_i  input  2  R response
rlast_i  input  1  last beat
rid_i  input  4  R id; ignored, because only one burst is outstanding

Behaviour:
- Reset (synchronous, active-high): state IDLE. req_ready_o=0 during reset. arvalid_o=0, rready_o=0, resp_valid_o=0, resp_err_o=0, resp_line_o=0, araddr_o=0, beat counter=0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready_o=1 only in this state. On req_valid_i & req_ready_o:
  - latch base = req_addr_i with the low log2(4*LINE_WORDS) bits cleared;
  - clear the line buffer, the error flag and the beat counter;
  - go to ADDR.
- ADDR: arvalid_o=1 and araddr_o=base. The AR fields stay stable until arready_i is sampled high; then go to DATA. arvalid_o is asserted the cycle after request acceptance.
- DATA: rready_o=1 for the whole state. On each rvalid_i beat:
  - word[cnt] = rdata_i[63:32] if bit 2 of (base + 4*cnt) is 1, else rdata_i[31:0];
  - error flag |= (rresp_i != 0);
  - cnt increments.
- End of burst is the first beat with rlast_i=1 or cnt==LINE_WORDS-1. Go to RESP on the next cycle.
- Wrong burst length sets the error flag:
  - rlast_i on a beat with cnt < LINE_WORDS-1 (early last);
  - rlast_i=0 on the beat with cnt==LINE_WORDS-1 (missing last).
  Any beats after a missing last are not consumed by this block.
- RESP: resp_valid_o=1. resp_line_o and resp_err_o are held stable until resp_ready_i. On handshake go to IDLE; the next request can be accepted the following cycle.
- Request-to-response latency is at least 2 + LINE_WORDS cycles with a zero-wait slave.
- Only one burst is outstanding at a time. req_valid_i arriving outside IDLE is left pending and not accepted.
- rvalid_i outside DATA is ignored; rready_o=0 there.
- resp_line_o is valid only while resp_valid_o=1. The line buffer keeps its value otherwise and is cleared on acceptance of a request.
- Reset mid-burst: returns to IDLE immediately and drops the partial line. The downstream slave shares the same reset.

Test Plan:
- Basic fill (LINE_WORDS=4): req_addr=0x8000_0014, zero-wait slave returning beat data {0x1111_1111 lane, …} for words 0x8000_0010..1C → araddr_o=0x8000_0010, arlen_o=3, arsize_o=2, arburst_o=1. Lane select: words 0x10/0x18 taken from [31:0], 0x14/0x1C from [63:32]. resp_line_o assembles in address order, resp_err_o=0, resp_valid_o 6 cycles after acceptance.
- AR backpressure: arready_i held low 5 cycles → arvalid_o stays high and araddr_o stays stable; exactly one AR handshake.
- R stalls and resp backpressure: rvalid_i gapped on alternate cycles, resp_ready_i low for 3 cycles → line correct, resp_valid_o/resp_line_o stable during the stall, req_ready_o=0 until the handshake.
- Error beat: rresp_i=2'b10 on beat 1 only → resp_err_o=1, remaining words still captured.
- Early rlast on beat 2 → RESP after 3 beats with resp_err_o=1. rlast missing on beat 3 → RESP after the 4th beat with resp_err_o=1.
- Reset asserted in DATA after 2 beats → next cycle all outputs at reset values. A new request then completes normally with a cleared error flag.
